// File: rtl/clock_divider_multi_if.sv
// -----------------------------------------------------------------------------
// clock_divider_multi_if
//
// Bundles the control, configuration and output signals of
// clock_divider_multi. The clock and reset stay plain ports on the divider.
//
// Signals:
//   ch_en       [NUM_CH]  per-channel enable
//   sync                  one-cycle pulse restarting all enabled channels
//   cfg_we                configuration write strobe
//   cfg_sel     [CH_W]    channel addressed by cfg_we
//   cfg_period  [CNT_W]   new period in clock cycles
//   cfg_high    [CNT_W]   new high time in clock cycles
//   clk_out     [NUM_CH]  divided waveform per channel (registered)
//   tick        [NUM_CH]  one-cycle pulse at the start of each period
//
// Modports:
//   master  drives control/configuration, observes outputs
//   slave   the divider itself
// -----------------------------------------------------------------------------
interface clock_divider_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 27
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] ch_en;
    logic              sync;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_sel;
    logic [CNT_W-1:0]  cfg_period;
    logic [CNT_W-1:0]  cfg_high;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    modport master (
        output ch_en,
        output sync,
        output cfg_we,
        output cfg_sel,
        output cfg_period,
        output cfg_high,
        input  clk_out,
        input  tick
    );

    modport slave (
        input  ch_en,
        input  sync,
        input  cfg_we,
        input  cfg_sel,
        input  cfg_period,
        input  cfg_high,
        output clk_out,
        output tick
    );
endinterface

// File: rtl/clock_divider_multi.sv
// -----------------------------------------------------------------------------
// clock_divider_multi
//
// Multi-channel programmable clock divider. Each channel produces a registered
// divided waveform (clk_out) and a one-cycle period-start pulse (tick) with a
// run-time programmable period and high time. New settings are written into
// shadow registers and only become active at a period boundary, so periods are
// never truncated or stretched except by sync or disable.
//
// Ports:
//   clock     system clock, rising edge
//   reset_n   asynchronous active-low reset
//   bus       clock_divider_multi_if.slave:
//               ch_en, sync, cfg_we, cfg_sel, cfg_period, cfg_high (in)
//               clk_out, tick (out)
//
// Parameters:
//   NUM_CH      number of channels (1..16)
//   CNT_W       counter / period / high-time width
//   DEF_PERIOD  period loaded at reset
//   DEF_HIGH    high time loaded at reset
// -----------------------------------------------------------------------------
module clock_divider_multi #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 27,
    parameter int DEF_PERIOD = 72000000,
    parameter int DEF_HIGH   = 36000000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    clock_divider_multi_if.slave  bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);
    localparam logic [CNT_W-1:0] RST_PER   = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] RST_HIGH  = CNT_W'(DEF_HIGH);

    logic [NUM_CH-1:0] clk_out_all;
    logic [NUM_CH-1:0] tick_all;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] p_sh_q,  p_sh_d;
        logic [CNT_W-1:0] h_sh_q,  h_sh_d;
        logic [CNT_W-1:0] p_act_q, p_act_d;
        logic [CNT_W-1:0] h_act_q, h_act_d;
        logic [CNT_W-1:0] cnt_q,   cnt_d;
        logic             run_q,   run_d;
        logic             clk_q,   clk_d;
        logic             tick_q,  tick_d;

        logic wr_hit;
        logic act_valid;
        logic sh_valid;
        logic at_wrap;

        // Out-of-range selects never match any channel and are dropped.
        assign wr_hit    = bus.cfg_we && (bus.cfg_sel == CH_W'(gi));

        // Periods below 2 cannot produce a waveform; the channel parks at a
        // boundary and re-evaluates the shadow period every edge.
        assign act_valid = (p_act_q >= CNT_TWO);
        assign sh_valid  = (p_sh_q >= CNT_TWO);
        assign at_wrap   = act_valid && (cnt_q == (p_act_q - CNT_ONE));

        // Shadow registers: written by the config port only.
        always_comb begin
            p_sh_d = p_sh_q;
            h_sh_d = h_sh_q;
            if (wr_hit) begin
                p_sh_d = bus.cfg_period;
                h_sh_d = bus.cfg_high;
            end
        end

        // Channel sequencing. Every boundary (start, sync, wrap, or parked on
        // an invalid period) loads the active registers from the pre-edge
        // shadow values, so a write landing on a boundary edge waits one more
        // period before taking effect.
        always_comb begin
            p_act_d = p_act_q;
            h_act_d = h_act_q;
            cnt_d   = cnt_q;
            run_d   = run_q;
            clk_d   = 1'b0;
            tick_d  = 1'b0;

            if (!bus.ch_en[gi]) begin
                p_act_d = p_sh_q;
                h_act_d = h_sh_q;
                cnt_d   = CNT_ZERO;
                run_d   = 1'b0;
            end else if (bus.sync || !run_q || !act_valid || at_wrap) begin
                p_act_d = p_sh_q;
                h_act_d = h_sh_q;
                cnt_d   = CNT_ZERO;
                run_d   = 1'b1;
                tick_d  = sh_valid;
                clk_d   = sh_valid && (h_sh_q != CNT_ZERO);
            end else begin
                cnt_d   = cnt_q + CNT_ONE;
                clk_d   = (cnt_d < h_act_q);
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                p_sh_q  <= RST_PER;
                h_sh_q  <= RST_HIGH;
                p_act_q <= RST_PER;
                h_act_q <= RST_HIGH;
                cnt_q   <= CNT_ZERO;
                run_q   <= 1'b0;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                p_sh_q  <= p_sh_d;
                h_sh_q  <= h_sh_d;
                p_act_q <= p_act_d;
                h_act_q <= h_act_d;
                cnt_q   <= cnt_d;
                run_q   <= run_d;
                clk_q   <= clk_d;
                tick_q  <= tick_d;
            end
        end

        assign clk_out_all[gi] = clk_q;
        assign tick_all[gi]    = tick_q;
    end

    assign bus.clk_out = clk_out_all;
    assign bus.tick    = tick_all;
endmodule

// File: tb/tb_clock_divider_multi.sv
// -----------------------------------------------------------------------------
// tb_clock_divider_multi
//
// Directed bench for clock_divider_multi. Five channels are built so that
// channel selects 5..7 are out of range; reset defaults are shrunk to
// period 6 / high 3. The stimulus process lists the hand-derived waveform of
// every channel as short repeating strings; each cycle it pushes the expected
// clk_out/tick vectors for the coming sample point, and an independent monitor
// pops and compares them on the falling edge.
// -----------------------------------------------------------------------------
module tb_clock_divider_multi;
    localparam int NCH = 5;
    localparam int CW  = 8;
    localparam int CHW = 3;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    clock_divider_multi_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

    clock_divider_multi #(
        .NUM_CH    (NCH),
        .CNT_W     (CW),
        .DEF_PERIOD(6),
        .DEF_HIGH  (3)
    ) dut (
        .clock  (clk),
        .reset_n(rst_n),
        .bus    (bus.slave)
    );

    typedef struct {
        string          name;
        logic [NCH-1:0] exp_clk;
        logic [NCH-1:0] exp_tick;
    } exp_t;

    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    stim_done = 1'b0;

    string cpat[NCH];
    string tpat[NCH];
    int    pos[NCH];

    // ---------------- scoreboard helpers ----------------
    task automatic set_pat(input int ch, input string c, input string t);
        cpat[ch] = c;
        tpat[ch] = t;
        pos[ch]  = 0;
    endtask

    task automatic all_zero_pat();
        for (int ch = 0; ch < NCH; ch++) set_pat(ch, "0", "0");
    endtask

    task automatic push_from_pat(input string name);
        exp_t e;
        e.name = name;
        for (int ch = 0; ch < NCH; ch++) begin
            e.exp_clk[ch]  = (cpat[ch].getc(pos[ch] % cpat[ch].len()) == "1");
            e.exp_tick[ch] = (tpat[ch].getc(pos[ch] % tpat[ch].len()) == "1");
            pos[ch]++;
        end
        exp_q.push_back(e);
    endtask

    task automatic push_zero(input string name);
        exp_t e;
        e.name     = name;
        e.exp_clk  = '0;
        e.exp_tick = '0;
        exp_q.push_back(e);
    endtask

    // Inputs set before the call are sampled by the next rising edge; the
    // expectation pushed just after that edge is checked on the falling edge.
    task automatic run(input int n, input string name);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            push_from_pat(name);
        end
    endtask

    task automatic cfg(input int sel, input int p, input int h);
        bus.cfg_we     = 1'b1;
        bus.cfg_sel    = CHW'(sel);
        bus.cfg_period = CW'(p);
        bus.cfg_high   = CW'(h);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (bus.clk_out !== e.exp_clk) begin
                    n_fail++;
                    $display("FAIL %s clk_out: got %b expected %b at %0t",
                             e.name, bus.clk_out, e.exp_clk, $time);
                end
                n_checks++;
                if (bus.tick !== e.exp_tick) begin
                    n_fail++;
                    $display("FAIL %s tick: got %b expected %b at %0t",
                             e.name, bus.tick, e.exp_tick, $time);
                end
                $display("[%0t] %s clk_out=%b tick=%b", $time, e.name, bus.clk_out, bus.tick);
            end else if (stim_done) begin
                break;
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        rst_n          = 1'b0;
        bus.ch_en      = '1;
        bus.sync       = 1'b0;
        bus.cfg_we     = 1'b0;
        bus.cfg_sel    = '0;
        bus.cfg_period = '0;
        bus.cfg_high   = '0;

        // Reset held with all channels enabled: everything low.
        all_zero_pat();
        run(3, "reset_hold");

        // Release: defaults P=6 H=3 on every channel, tick on first edge.
        rst_n = 1'b1;
        for (int ch = 0; ch < NCH; ch++) set_pat(ch, "111000", "100000");
        run(12, "defaults");

        // Disable ch1..4 while programming ch1 with P=5 H=2; ch0 keeps running.
        bus.ch_en = 5'b00001;
        for (int ch = 1; ch < NCH; ch++) set_pat(ch, "0", "0");
        cfg(1, 5, 2);
        run(1, "disable_write");
        bus.cfg_we = 1'b0;
        run(1, "disabled");

        // Enable ch1: 1,1,0,0,0 with tick on the first 1.
        bus.ch_en = 5'b00011;
        set_pat(1, "11000", "10000");
        run(13, "ch1_p5h2");

        // Write P=3 H=1 at cnt=2: current period finishes (cnt 3,4) first.
        cfg(1, 3, 1);
        set_pat(1, "00", "00");
        run(1, "midwrite_tail");
        bus.cfg_we = 1'b0;
        run(1, "midwrite_tail");
        set_pat(1, "100", "100");
        run(9, "ch1_p3h1");

        // Write P=4 H=3 on the wrap edge: one more 3/1 period, then 4/3.
        cfg(1, 4, 3);
        run(1, "wrapwrite_old");
        bus.cfg_we = 1'b0;
        run(2, "wrapwrite_old");
        set_pat(1, "1110", "1000");
        run(8, "ch1_p4h3");

        // Sync test: program ch0..3 while disabled.
        bus.ch_en = '0;
        all_zero_pat();
        cfg(0, 4, 2); run(1, "sync_cfg");
        cfg(1, 6, 3); run(1, "sync_cfg");
        cfg(2, 8, 4); run(1, "sync_cfg");
        cfg(3, 3, 1); run(1, "sync_cfg");
        bus.cfg_we = 1'b0;

        // Staggered enables so channels are out of phase before the sync.
        bus.ch_en = 5'b01001;
        set_pat(0, "1100", "1000");
        set_pat(3, "100", "100");
        run(2, "pre_sync");
        bus.ch_en = 5'b01011;
        set_pat(1, "111000", "100000");
        run(5, "pre_sync");

        // Sync: all enabled channels restart together; ch2/ch4 stay low.
        bus.sync = 1'b1;
        set_pat(0, "1100", "1000");
        set_pat(1, "111000", "100000");
        set_pat(3, "100", "100");
        run(1, "sync_edge");
        bus.sync = 1'b0;
        run(11, "post_sync");

        // Boundaries: P=1, P=0, H=0, H>P.
        bus.ch_en = '0;
        all_zero_pat();
        cfg(0, 1, 1); run(1, "bnd_cfg");
        cfg(1, 0, 3); run(1, "bnd_cfg");
        cfg(2, 4, 0); run(1, "bnd_cfg");
        cfg(3, 5, 7); run(1, "bnd_cfg");
        bus.cfg_we = 1'b0;
        bus.ch_en = 5'b01111;
        set_pat(0, "0", "0");
        set_pat(1, "0", "0");
        set_pat(2, "0", "1000");
        set_pat(3, "1", "10000");
        run(12, "boundaries");

        // Parked ch0 picks up a valid period on the edge after the write.
        cfg(0, 3, 2);
        set_pat(0, "0", "0");
        run(1, "recover_write");
        bus.cfg_we = 1'b0;
        set_pat(0, "110", "100");
        run(6, "recovered");

        // Out-of-range selects must change nothing.
        cfg(5, 2, 0); run(1, "bad_sel");
        cfg(6, 2, 0); run(1, "bad_sel");
        cfg(7, 2, 0); run(1, "bad_sel");
        bus.cfg_we = 1'b0;
        bus.sync = 1'b1;
        set_pat(0, "110", "100");
        set_pat(1, "0", "0");
        set_pat(2, "0", "1000");
        set_pat(3, "1", "10000");
        run(1, "bad_sel_sync");
        bus.sync = 1'b0;
        run(10, "bad_sel_after");

        // ch1 to P=5 H=3 (still parked on P=0, so it starts one edge later).
        cfg(1, 5, 3);
        set_pat(1, "0", "0");
        run(1, "ch1_reprog");
        bus.cfg_we = 1'b0;
        set_pat(1, "11100", "10000");
        run(2, "ch1_p5h3");

        // Drop ch_en on ch1 mid-high: low from the next edge.
        bus.ch_en = 5'b01101;
        set_pat(1, "0", "0");
        run(3, "ch1_dropped");

        // Asynchronous reset between edges: outputs low before any edge.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        push_zero("async_reset");
        all_zero_pat();
        run(2, "reset_hold2");

        // Release with only ch1 enabled: fresh full default period.
        rst_n = 1'b1;
        bus.ch_en = 5'b00010;
        set_pat(1, "111000", "100000");
        run(13, "after_reset");

        stim_done = 1'b1;
    end
endmodule
